taus_rr_server: RTL and testbench

Round-robin server that shares one combined three-component Tausworthe (taus88) generator among `N_REQ` requesters. It owns the generator state, sequences seeding and a fixed warm-up discard, and hands out one 32-bit random word per grant. It sits between the Tausworthe datapath and the consumer blocks that need random words.

---
 rtl/taus_pkg.sv | 29 ++
 rtl/taus_rr_server_if.sv | 14 +
 rtl/taus88_step.sv | 19 +
 rtl/taus_rr_server.sv | 137 +++++++++++++
 tb/tb_taus_rr_server.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/taus_pkg.sv
// rtl/taus_pkg.sv - shared taus88 constants and server state encoding
package taus_pkg;

    localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
    localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;

    // Per component: inner left shift, right shift, masked left shift
    localparam int SH_Q1 = 13;
    localparam int SH_S1 = 19;
    localparam int SH_P1 = 12;
    localparam int SH_Q2 = 2;
    localparam int SH_S2 = 25;
    localparam int SH_P2 = 4;
    localparam int SH_Q3 = 3;
    localparam int SH_S3 = 11;
    localparam int SH_P3 = 17;

    localparam logic [31:0] RESEED_X2  = 32'h9E37_79B9;
    localparam logic [31:0] RESEED_X3  = 32'h7F4A_7C15;
    // Bit 4 forced on keeps every component above its degenerate minimum
    localparam logic [31:0] SEED_FLOOR = 32'h0000_0010;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } srv_state_t;

endpackage

// File: rtl/taus_rr_server_if.sv
// rtl/taus_rr_server_if.sv - requester-side bus of the random word server
interface taus_rr_server_if #(
    parameter int N_REQ = 4
);
    logic             seed_load;
    logic [31:0]      seed;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [31:0]      data;
    logic             busy;

    modport master (output seed_load, seed, req, input gnt, data, busy);
    modport slave  (input seed_load, seed, req, output gnt, data, busy);
endinterface

// File: rtl/taus88_step.sv
// rtl/taus88_step.sv - combinational taus88 state step and output word
module taus88_step
    import taus_pkg::*;
(
    input  logic [31:0] s1_in,
    input  logic [31:0] s2_in,
    input  logic [31:0] s3_in,
    output logic [31:0] s1_out,
    output logic [31:0] s2_out,
    output logic [31:0] s3_out,
    output logic [31:0] word
);
    assign s1_out = ((s1_in & MASK1) << SH_P1) ^ (((s1_in << SH_Q1) ^ s1_in) >> SH_S1);
    assign s2_out = ((s2_in & MASK2) << SH_P2) ^ (((s2_in << SH_Q2) ^ s2_in) >> SH_S2);
    assign s3_out = ((s3_in & MASK3) << SH_P3) ^ (((s3_in << SH_Q3) ^ s3_in) >> SH_S3);

    // Output is taken from the state before the step
    assign word = s1_in ^ s2_in ^ s3_in;
endmodule

// File: rtl/taus_rr_server.sv
// rtl/taus_rr_server.sv - round-robin server sharing one taus88 generator
module taus_rr_server
    import taus_pkg::*;
#(
    parameter int          N_REQ  = 4,
    parameter int          WARMUP = 16,
    parameter logic [31:0] SEED1  = 32'h0000_1234,
    parameter logic [31:0] SEED2  = 32'h0000_5678,
    parameter logic [31:0] SEED3  = 32'h0009_ABCD
) (
    input  logic             clk,
    input  logic             rst_n,
    taus_rr_server_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [31:0]      s1, s2, s3;
    logic [31:0]      s1_nx, s2_nx, s3_nx, word;
    srv_state_t       st, st_nx;
    logic [7:0]       cnt, cnt_nx;
    // Index where the next round-robin search begins (one past the last winner)
    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] gnt_r;
    logic [31:0]      data_r;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    idx;
    logic             found;
    int               sum;
    logic             step_en;
    logic             grant;

    taus88_step u_step (
        .s1_in  (s1),
        .s2_in  (s2),
        .s3_in  (s3),
        .s1_out (s1_nx),
        .s2_out (s2_nx),
        .s3_out (s3_nx),
        .word   (word)
    );

    assign bus.gnt  = gnt_r;
    assign bus.data = data_r;
    assign bus.busy = (st == WARM);

    // Round-robin pick among requesters not granted last cycle
    always_comb begin
        elig    = bus.req & ~gnt_r;
        win_oh  = '0;
        win_idx = '0;
        idx     = '0;
        sum     = 0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            idx = PW'(sum);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                win_idx     = idx;
                win_oh[idx] = 1'b1;
            end
        end
    end

    // Next state, warm-up counting and step/grant enables; reseed overrides all
    always_comb begin
        st_nx   = st;
        cnt_nx  = cnt;
        step_en = 1'b0;
        grant   = 1'b0;
        case (st)
            WARM: begin
                step_en = 1'b1;
                if (cnt == 8'(WARMUP - 1)) begin
                    st_nx  = RUN;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RUN: begin
                if (found) begin
                    grant   = 1'b1;
                    step_en = 1'b1;
                end
            end
        endcase
        if (bus.seed_load) begin
            st_nx   = WARM;
            cnt_nx  = '0;
            step_en = 1'b0;
            grant   = 1'b0;
        end
    end

    // State machine and warm-up counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= WARM;
            cnt <= '0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    // Generator state, grant pulse, output word and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= SEED1;
            s2     <= SEED2;
            s3     <= SEED3;
            gnt_r  <= '0;
            data_r <= '0;
            ptr    <= '0;
        end else begin
            if (bus.seed_load) begin
                s1 <= bus.seed | SEED_FLOOR;
                s2 <= (bus.seed ^ RESEED_X2) | SEED_FLOOR;
                s3 <= (bus.seed ^ RESEED_X3) | SEED_FLOOR;
            end else if (step_en) begin
                s1 <= s1_nx;
                s2 <= s2_nx;
                s3 <= s3_nx;
            end
            gnt_r <= grant ? win_oh : '0;
            if (grant) begin
                data_r <= word;
                ptr    <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_taus_rr_server.sv
// tb/tb_taus_rr_server.sv - directed self-checking bench for taus_rr_server
module tb_taus_rr_server;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] m1, m2, m3;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    taus_rr_server_if #(.N_REQ(4)) bus ();

    taus_rr_server #(
        .N_REQ  (4),
        .WARMUP (16),
        .SEED1  (32'h0000_1234),
        .SEED2  (32'h0000_5678),
        .SEED3  (32'h0009_ABCD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m1 = 32'h0000_1234;
        m2 = 32'h0000_5678;
        m3 = 32'h0009_ABCD;
    endtask

    task automatic m_reseed(input logic [31:0] s);
        m1 = s | 32'h10;
        m2 = (s ^ 32'h9E37_79B9) | 32'h10;
        m3 = (s ^ 32'h7F4A_7C15) | 32'h10;
    endtask

    task automatic m_step();
        m1 = ((m1 & 32'hFFFF_FFFE) << 12) ^ (((m1 << 13) ^ m1) >> 19);
        m2 = ((m2 & 32'hFFFF_FFF8) << 4)  ^ (((m2 << 2)  ^ m2) >> 25);
        m3 = ((m3 & 32'hFFFF_FFF0) << 17) ^ (((m3 << 3)  ^ m3) >> 11);
    endtask

    // Samples the current cycle then n more edges; busy must be high for exactly 16 samples
    task automatic warm_check(input string tag, input int n);
        int busy_cnt;
        int gnt_cnt;
        busy_cnt = 0;
        gnt_cnt  = 0;
        if (bus.busy) busy_cnt++;
        if (bus.gnt != 4'b0) gnt_cnt++;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.gnt != 4'b0) gnt_cnt++;
        end
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd16);
        chk({tag, "_gnt_during_warm"}, gnt_cnt, 32'd0);
        chk({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
        for (int i = 0; i < 16; i++) m_step();
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] exp_gnt);
        tick();
        chk({tag, "_gnt"}, {28'b0, bus.gnt}, {28'b0, exp_gnt});
        chk({tag, "_data"}, bus.data, m1 ^ m2 ^ m3);
        m_step();
        last_data = bus.data;
    endtask

    initial begin
        logic [3:0] order4 [4];
        order4[0] = 4'b0001;
        order4[1] = 4'b0010;
        order4[2] = 4'b0100;
        order4[3] = 4'b1000;
        bus.seed_load = 1'b0;
        bus.seed      = 32'h0;
        bus.req       = 4'b0;
        last_data     = 32'h0;

        // Reset state
        #12;
        chk("rst_busy", {31'b0, bus.busy}, 32'd1);
        chk("rst_gnt", {28'b0, bus.gnt}, 32'd0);
        chk("rst_data", bus.data, 32'd0);
        tick();
        rst_n = 1'b1;
        m_reset();
        warm_check("warm1", 16);

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) expect_grant($sformatf("rr%0d", i), order4[i % 4]);
        bus.req = 4'b0;
        tick();
        chk("rr_idle_gnt", {28'b0, bus.gnt}, 32'd0);
        chk("rr_idle_data_hold", bus.data, last_data);

        // Single requester: granted every other cycle, generator stepping only then
        bus.req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                expect_grant($sformatf("single%0d", i), 4'b0100);
            end else begin
                tick();
                chk($sformatf("single%0d_gnt", i), {28'b0, bus.gnt}, 32'd0);
                chk($sformatf("single%0d_hold", i), bus.data, last_data);
            end
        end
        bus.req = 4'b0;
        tick();

        // Reseed with zero while requests pending; pointer continues at index 3
        bus.req       = 4'b1011;
        bus.seed_load = 1'b1;
        bus.seed      = 32'h0000_0000;
        tick();
        bus.seed_load = 1'b0;
        chk("reseed_gnt", {28'b0, bus.gnt}, 32'd0);
        m_reseed(32'h0000_0000);
        warm_check("warm2", 16);
        expect_grant("post_seed0", 4'b1000);
        expect_grant("post_seed1", 4'b0001);
        expect_grant("post_seed2", 4'b0010);

        // Reseed on the same edge an eligible request (1001) is sampled
        bus.seed_load = 1'b1;
        bus.seed      = 32'hDEAD_BEEF;
        tick();
        bus.seed_load = 1'b0;
        chk("collide_gnt", {28'b0, bus.gnt}, 32'd0);
        chk("collide_busy", {31'b0, bus.busy}, 32'd1);
        m_reseed(32'hDEAD_BEEF);
        warm_check("warm3", 16);
        expect_grant("post_coll0", 4'b1000);
        expect_grant("post_coll1", 4'b0001);
        expect_grant("post_coll2", 4'b0010);

        // Asynchronous reset in the middle of a grant cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", {28'b0, bus.gnt}, 32'd0);
        chk("async_data", bus.data, 32'd0);
        chk("async_busy", {31'b0, bus.busy}, 32'd1);
        bus.req = 4'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_reset();
        warm_check("warm4", 16);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) expect_grant($sformatf("rr_again%0d", i), order4[i]);
        bus.req = 4'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
